// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with optional parity, 1 or 2 stop bits and a one-entry holding buffer.
module uart_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enableTx,
  input  logic [7:0] i_bitsTx,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_pending,
  output logic       o_done,
  output logic       o_overrun
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic [7:0] data_q, data_d, buf_q, buf_d;
  logic pend_q, pend_d, tx_q, tx_d, ovr_q, ovr_d;
  logic last, fin;
  always_comb begin
    last = cnt_q == CW'(CLKS_PER_BIT - 1);
    fin = state_q == STOP && last && stop_q == 1'(STOP_BITS - 1);
    state_d = state_q;
    cnt_d = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    stop_d = stop_q;
    data_d = data_q;
    buf_d = buf_q;
    pend_d = pend_q;
    ovr_d = 1'b0;
    case (state_q)
      IDLE: if (i_enableTx) begin
        state_d = START;
        data_d = i_bitsTx;
      end
      START: if (last) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (last) begin
        bit_d = bit_q == 3'd7 ? bit_q : bit_q + 1'b1;
        if (bit_q == 3'd7) begin
          state_d = PARITY_EN != 0 ? PARITY : STOP;
          stop_d = 1'b0;
        end
      end
      PARITY: if (last) begin
        state_d = STOP;
        stop_d = 1'b0;
      end
      STOP: if (last) stop_d = 1'b1;
      default: state_d = IDLE;
    endcase
    // The last stop cycle hands off to the buffered byte (or a fresh request) with no idle gap
    if (fin) begin
      state_d = (pend_q || i_enableTx) ? START : IDLE;
      data_d = pend_q ? buf_q : i_enableTx ? i_bitsTx : data_q;
      pend_d = pend_q && i_enableTx;
      buf_d = (pend_q && i_enableTx) ? i_bitsTx : buf_q;
    end else if (state_q != IDLE && i_enableTx) begin
      ovr_d = pend_q;
      pend_d = 1'b1;
      buf_d = pend_q ? buf_q : i_bitsTx;
    end
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA ? data_d[bit_d] :
           state_d == PARITY ? (^data_d) ^ (PARITY_ODD != 0) : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      stop_q <= 1'b0;
      data_q <= '0;
      buf_q <= '0;
      pend_q <= 1'b0;
      tx_q <= 1'b1;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      stop_q <= stop_d;
      data_q <= data_d;
      buf_q <= buf_d;
      pend_q <= pend_d;
      tx_q <= tx_d;
      ovr_q <= ovr_d;
    end
  end
  assign o_tx = tx_q;
  assign o_busy = state_q != IDLE;
  assign o_pending = pend_q;
  assign o_done = fin;
  assign o_overrun = ovr_q;
endmodule
